// File: rtl/spi_pkg.sv
// Shared types, widths and bit-order helpers for the SPI mode-0 responder.
package spi_pkg;

   localparam int unsigned SPI_BYTE_W   = 8;
   localparam int unsigned SPI_BITCNT_W = 3;

   typedef enum logic [1:0] {
      RESYNC = 2'd0,
      IDLE   = 2'd1,
      ACTIVE = 2'd2
   } spi_slave_state_t;

   // Shift one bit into a byte at the end chosen by the bit order (0 = MSB first).
   function automatic logic [SPI_BYTE_W-1:0] spi_shift(input logic [SPI_BYTE_W-1:0] sh,
                                                      input logic bit_in,
                                                      input logic lsb_first);
      return lsb_first ? {bit_in, sh[SPI_BYTE_W-1:1]} : {sh[SPI_BYTE_W-2:0], bit_in};
   endfunction

   function automatic logic spi_first_bit(input logic [SPI_BYTE_W-1:0] b, input logic lsb_first);
      return lsb_first ? b[0] : b[SPI_BYTE_W-1];
   endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Synchroniser chain plus delay flop; level and edge strobes are all registered.
module spi_sync_edge #(
   parameter int unsigned STAGES  = 2,
   parameter logic        RST_VAL = 1'b0
) (
   input  logic clk,
   input  logic arstn,
   input  logic din,
   output logic level,
   output logic rise,
   output logic fall
);

   logic [STAGES-1:0] sync_q, sync_d;
   logic              dly_q, dly_d;
   logic              rise_q, rise_d;
   logic              fall_q, fall_d;

   always_comb begin
      sync_d = {sync_q[STAGES-2:0], din};
      dly_d  = sync_q[STAGES-1];
      rise_d = sync_q[STAGES-1] & ~dly_q;
      fall_d = ~sync_q[STAGES-1] & dly_q;
   end

   always_ff @(posedge clk or negedge arstn) begin
      if (!arstn) begin
         sync_q <= {STAGES{RST_VAL}};
         dly_q  <= RST_VAL;
         rise_q <= 1'b0;
         fall_q <= 1'b0;
      end else begin
         sync_q <= sync_d;
         dly_q  <= dly_d;
         rise_q <= rise_d;
         fall_q <= fall_d;
      end
   end

   assign level = dly_q;
   assign rise  = rise_q;
   assign fall  = fall_q;

endmodule

// File: rtl/spi_slave.sv
// SPI mode-0 responder: oversampled scl/cs/mosi, byte deserialiser and miso serialiser.
module spi_slave
   import spi_pkg::*;
#(
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic                  clk,
   input  logic                  arstn,
   input  logic                  scl,
   input  logic                  cs,
   input  logic                  mosi,
   output logic                  miso,
   input  logic                  msb_lsb,
   input  logic [SPI_BYTE_W-1:0] tx_byte,
   output logic                  tx_ready,
   output logic [SPI_BYTE_W-1:0] rx_byte,
   output logic                  rx_valid,
   output logic                  busy,
   output logic                  frame_end
);

   // The cs chain resets high, so its level is meaningless until the chain has flushed.
   localparam int unsigned SETTLE   = SYNC_STAGES + 1;
   localparam int unsigned SETTLE_W = $clog2(SETTLE + 1);

   logic scl_level_unused, scl_rise, scl_fall;
   logic cs_level, cs_rise, cs_fall;
   logic mosi_level, mosi_rise_unused, mosi_fall_unused;

   spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_scl_sync (
      .clk(clk), .arstn(arstn), .din(scl),
      .level(scl_level_unused), .rise(scl_rise), .fall(scl_fall));

   spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_cs_sync (
      .clk(clk), .arstn(arstn), .din(cs),
      .level(cs_level), .rise(cs_rise), .fall(cs_fall));

   spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_mosi_sync (
      .clk(clk), .arstn(arstn), .din(mosi),
      .level(mosi_level), .rise(mosi_rise_unused), .fall(mosi_fall_unused));

   spi_slave_state_t        state_q, state_d;
   logic [SETTLE_W-1:0]     settle_q, settle_d;
   logic [SPI_BYTE_W-1:0]   rx_sh_q, rx_sh_d;
   logic [SPI_BYTE_W-1:0]   tx_sh_q, tx_sh_d;
   logic [SPI_BITCNT_W-1:0] bit_cnt_q, bit_cnt_d;
   logic                    reload_q, reload_d;
   logic                    lsb_q, lsb_d;
   logic                    miso_q, miso_d;
   logic [SPI_BYTE_W-1:0]   rx_byte_q, rx_byte_d;
   logic                    rx_valid_q, rx_valid_d;
   logic                    tx_ready_q, tx_ready_d;
   logic                    busy_q, busy_d;
   logic                    frame_end_q, frame_end_d;

   always_comb begin
      state_d     = state_q;
      settle_d    = settle_q;
      rx_sh_d     = rx_sh_q;
      tx_sh_d     = tx_sh_q;
      bit_cnt_d   = bit_cnt_q;
      reload_d    = reload_q;
      lsb_d       = lsb_q;
      miso_d      = miso_q;
      rx_byte_d   = rx_byte_q;
      rx_valid_d  = 1'b0;
      tx_ready_d  = 1'b0;
      frame_end_d = 1'b0;

      case (state_q)
         RESYNC: begin
            miso_d = 1'b0;
            if (settle_q != SETTLE_W'(SETTLE)) begin
               settle_d = settle_q + SETTLE_W'(1);
            end else if (cs_level) begin
               state_d = IDLE;
            end
         end
         IDLE: begin
            if (cs_fall) begin
               lsb_d      = msb_lsb;
               tx_sh_d    = spi_shift(tx_byte, 1'b0, msb_lsb);
               miso_d     = spi_first_bit(tx_byte, msb_lsb);
               tx_ready_d = 1'b1;
               bit_cnt_d  = '0;
               reload_d   = 1'b0;
               state_d    = ACTIVE;
            end
         end
         ACTIVE: begin
            // cs rise takes priority over any scl edge seen in the same cycle.
            if (cs_rise) begin
               frame_end_d = 1'b1;
               miso_d      = 1'b0;
               reload_d    = 1'b0;
               state_d     = IDLE;
            end else if (scl_rise) begin
               rx_sh_d   = spi_shift(rx_sh_q, mosi_level, lsb_q);
               bit_cnt_d = bit_cnt_q + SPI_BITCNT_W'(1);
               if (bit_cnt_q == '1) begin
                  rx_byte_d  = rx_sh_d;
                  rx_valid_d = 1'b1;
                  reload_d   = 1'b1;
               end
            end else if (scl_fall) begin
               if (reload_q) begin
                  lsb_d      = msb_lsb;
                  tx_sh_d    = spi_shift(tx_byte, 1'b0, msb_lsb);
                  miso_d     = spi_first_bit(tx_byte, msb_lsb);
                  tx_ready_d = 1'b1;
                  reload_d   = 1'b0;
               end else begin
                  miso_d  = spi_first_bit(tx_sh_q, lsb_q);
                  tx_sh_d = spi_shift(tx_sh_q, 1'b0, lsb_q);
               end
            end
         end
         default: begin
            state_d = RESYNC;
            miso_d  = 1'b0;
         end
      endcase

      busy_d = (state_d == ACTIVE);
   end

   always_ff @(posedge clk or negedge arstn) begin
      if (!arstn) begin
         state_q     <= RESYNC;
         settle_q    <= '0;
         rx_sh_q     <= '0;
         tx_sh_q     <= '0;
         bit_cnt_q   <= '0;
         reload_q    <= 1'b0;
         lsb_q       <= 1'b0;
         miso_q      <= 1'b0;
         rx_byte_q   <= '0;
         rx_valid_q  <= 1'b0;
         tx_ready_q  <= 1'b0;
         busy_q      <= 1'b0;
         frame_end_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         settle_q    <= settle_d;
         rx_sh_q     <= rx_sh_d;
         tx_sh_q     <= tx_sh_d;
         bit_cnt_q   <= bit_cnt_d;
         reload_q    <= reload_d;
         lsb_q       <= lsb_d;
         miso_q      <= miso_d;
         rx_byte_q   <= rx_byte_d;
         rx_valid_q  <= rx_valid_d;
         tx_ready_q  <= tx_ready_d;
         busy_q      <= busy_d;
         frame_end_q <= frame_end_d;
      end
   end

   assign miso      = miso_q;
   assign rx_byte   = rx_byte_q;
   assign rx_valid  = rx_valid_q;
   assign tx_ready  = tx_ready_q;
   assign busy      = busy_q;
   assign frame_end = frame_end_q;

endmodule

// File: tb/tb_spi_slave.sv
// Directed bench for spi_slave: table of single-byte frames plus continuous, abort and reset sequences.
module tb_spi_slave;

   localparam int HALF = 80;

   logic       clk = 1'b0;
   logic       arstn = 1'b0;
   logic       scl = 1'b0;
   logic       cs = 1'b1;
   logic       mosi = 1'b0;
   logic       msb_lsb = 1'b0;
   logic [7:0] tx_byte;
   logic [7:0] tx_fixed = 8'h00;
   logic       miso, tx_ready, rx_valid, busy, frame_end;
   logic [7:0] rx_byte;

   int n_vec = 0;
   int n_err = 0;
   int rx_cnt = 0;
   int fe_cnt = 0;
   logic [7:0] rx_log[$];
   bit  step_en = 1'b0;
   int  step_idx = 0;

   spi_slave #(.SYNC_STAGES(2)) dut (
      .clk(clk), .arstn(arstn), .scl(scl), .cs(cs), .mosi(mosi), .miso(miso),
      .msb_lsb(msb_lsb), .tx_byte(tx_byte), .tx_ready(tx_ready), .rx_byte(rx_byte),
      .rx_valid(rx_valid), .busy(busy), .frame_end(frame_end));

   always #5 clk = ~clk;

   function automatic logic [7:0] tx_seq(input int i);
      return 8'(32'hC0 + i * 7);
   endfunction

   // Sole driver of tx_byte: fixed value, or step through tx_seq on each tx_ready.
   always @(negedge clk) begin
      if (rx_valid) begin
         rx_cnt++;
         rx_log.push_back(rx_byte);
      end
      if (frame_end) fe_cnt++;
      if (!step_en) begin
         step_idx = 0;
         tx_byte  = tx_fixed;
      end else if (tx_ready) begin
         step_idx++;
         tx_byte = tx_seq(step_idx);
      end
   end

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %02h expected %02h", name, act, exp);
      end
   endtask

   // Master side: mosi changes while scl low, miso sampled at scl rise.
   task automatic xfer(input logic [7:0] tx, input int nbits, input logic lsb_first,
                       output logic [7:0] rx);
      rx = 8'h00;
      for (int i = 0; i < nbits; i++) begin
         mosi = lsb_first ? tx[i] : tx[7-i];
         #HALF;
         scl = 1'b1;
         if (lsb_first) rx[i] = miso;
         else           rx[7-i] = miso;
         #HALF;
         scl = 1'b0;
      end
   endtask

   task automatic frame_close();
      #HALF;
      cs = 1'b1;
      #(2 * HALF);
   endtask

   typedef struct {
      logic       lsb;
      logic [7:0] mosi_b;
      logic [7:0] tx_b;
      logic [7:0] exp_rx;
      logic [7:0] exp_miso;
   } vec_t;

   vec_t vecs[6];

   initial begin
      logic [7:0] got;
      int r0, f0;

      vecs[0] = '{1'b0, 8'hA5, 8'h3C, 8'hA5, 8'h3C};
      vecs[1] = '{1'b1, 8'h01, 8'h80, 8'h01, 8'h80};
      vecs[2] = '{1'b0, 8'hFF, 8'h00, 8'hFF, 8'h00};
      vecs[3] = '{1'b0, 8'h00, 8'hFF, 8'h00, 8'hFF};
      vecs[4] = '{1'b1, 8'h96, 8'h5A, 8'h96, 8'h5A};
      vecs[5] = '{1'b0, 8'h81, 8'h7E, 8'h81, 8'h7E};

      // Reset values, during and after reset
      repeat (3) @(negedge clk);
      check("rst_miso", 8'(miso), 8'h00);
      check("rst_rx_byte", rx_byte, 8'h00);
      check("rst_pulses", 8'({rx_valid, tx_ready, frame_end}), 8'h00);
      check("rst_busy", 8'(busy), 8'h00);
      arstn = 1'b1;
      repeat (10) @(negedge clk);
      check("post_rst_busy", 8'(busy), 8'h00);
      check("post_rst_rx_cnt", 8'(rx_cnt), 8'h00);

      // Table of single-byte frames
      foreach (vecs[k]) begin
         tx_fixed = vecs[k].tx_b;
         msb_lsb  = vecs[k].lsb;
         repeat (2) @(negedge clk);
         r0 = rx_cnt;
         f0 = fe_cnt;
         cs = 1'b0;
         xfer(vecs[k].mosi_b, 8, vecs[k].lsb, got);
         check($sformatf("v%0d_busy_active", k), 8'(busy), 8'h01);
         frame_close();
         check($sformatf("v%0d_rx_cnt", k), 8'(rx_cnt - r0), 8'h01);
         check($sformatf("v%0d_rx_byte", k), rx_byte, vecs[k].exp_rx);
         check($sformatf("v%0d_miso_byte", k), got, vecs[k].exp_miso);
         check($sformatf("v%0d_frame_end", k), 8'(fe_cnt - f0), 8'h01);
         check($sformatf("v%0d_busy_idle", k), 8'(busy), 8'h00);
         check($sformatf("v%0d_miso_idle", k), 8'(miso), 8'h00);
      end

      // Continuous transfer of 50 bytes with cs held low
      msb_lsb  = 1'b0;
      tx_fixed = tx_seq(0);
      repeat (2) @(negedge clk);
      step_en = 1'b1;
      @(negedge clk);
      rx_log.delete();
      r0 = rx_cnt;
      f0 = fe_cnt;
      cs = 1'b0;
      for (int i = 0; i < 50; i++) begin
         xfer(8'(56 + i), 8, 1'b0, got);
         check($sformatf("cont_miso_%0d", i), got, tx_seq(i));
      end
      frame_close();
      step_en = 1'b0;
      check("cont_rx_cnt", 8'(rx_cnt - r0), 8'd50);
      check("cont_frame_end", 8'(fe_cnt - f0), 8'h01);
      for (int i = 0; i < 50; i++) begin
         check($sformatf("cont_rx_%0d", i), (i < rx_log.size()) ? rx_log[i] : 8'hXX, 8'(56 + i));
      end

      // Abort after 5 rises, then a full byte
      tx_fixed = 8'h33;
      repeat (2) @(negedge clk);
      r0 = rx_cnt;
      f0 = fe_cnt;
      cs = 1'b0;
      xfer(8'hF0, 5, 1'b0, got);
      frame_close();
      check("abort_rx_cnt", 8'(rx_cnt - r0), 8'h00);
      check("abort_rx_byte", rx_byte, 8'd105);
      check("abort_frame_end", 8'(fe_cnt - f0), 8'h01);
      check("abort_busy", 8'(busy), 8'h00);
      r0 = rx_cnt;
      cs = 1'b0;
      xfer(8'h96, 8, 1'b0, got);
      frame_close();
      check("after_abort_rx_cnt", 8'(rx_cnt - r0), 8'h01);
      check("after_abort_rx_byte", rx_byte, 8'h96);
      check("after_abort_miso", got, 8'h33);

      // Reset mid-frame with cs still low
      tx_fixed = 8'h11;
      repeat (2) @(negedge clk);
      cs = 1'b0;
      xfer(8'hE0, 3, 1'b0, got);
      arstn = 1'b0;
      repeat (3) @(negedge clk);
      check("midrst_miso", 8'(miso), 8'h00);
      check("midrst_rx_byte", rx_byte, 8'h00);
      check("midrst_pulses", 8'({rx_valid, tx_ready, frame_end}), 8'h00);
      check("midrst_busy", 8'(busy), 8'h00);
      arstn = 1'b1;
      r0 = rx_cnt;
      f0 = fe_cnt;
      xfer(8'hFF, 8, 1'b0, got);
      check("midrst_ignored_busy", 8'(busy), 8'h00);
      check("midrst_ignored_miso", 8'(miso), 8'h00);
      frame_close();
      check("midrst_no_rx", 8'(rx_cnt - r0), 8'h00);
      check("midrst_no_frame_end", 8'(fe_cnt - f0), 8'h00);
      tx_fixed = 8'hC3;
      repeat (2) @(negedge clk);
      cs = 1'b0;
      xfer(8'h7E, 8, 1'b0, got);
      frame_close();
      check("midrst_new_rx_cnt", 8'(rx_cnt - r0), 8'h01);
      check("midrst_new_rx_byte", rx_byte, 8'h7E);
      check("midrst_new_miso", got, 8'hC3);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/spi_slave.md
# spi_slave

SPI mode-0 responder that sits at the far end of an SPI link driven by the team's `spi_interface` master. It oversamples `scl`, `cs` and `mosi` in the local clock domain, deserialises `mosi` into bytes, and serialises user-supplied bytes onto `miso`. It supports single-byte and continuous (back-to-back, `cs` held low) transfers, with selectable bit order. It is the synthesizable counterpart of the bench-side SPI slave agent.

## Interface
- `SYNC_STAGES`, default 2: synchroniser depth for `scl`, `cs` and `mosi`. Must be ≥ 2.
- `clk`, input, 1: system clock. Must satisfy CLK_FREC/SCL_FREC ≥ 2·(SYNC_STAGES+3).
- `arstn`, input, 1: asynchronous, active-low reset.
- `scl`, input, 1: SPI clock. Idles low (CPOL=0).
- `cs`, input, 1: chip select, active low.
- `mosi`, input, 1: master-to-slave data.
- `miso`, output, 1: slave-to-master data. Driven 0 when not selected.
- `msb_lsb`, input, 1: bit order. 0 = MSB first, 1 = LSB first. Sampled when a byte is loaded.
- `tx_byte`, input, 8: next byte to shift out on `miso`.
- `tx_ready`, output, 1: one-cycle pulse when `tx_byte` has been latched into the shifter.
- `rx_byte`, output, 8: last complete byte received. Held until the next byte completes.
- `rx_valid`, output, 1: one-cycle pulse when `rx_byte` updates.
- `busy`, output, 1: high while in state ACTIVE.
- `frame_end`, output, 1: one-cycle pulse on detected `cs` rising edge while ACTIVE.

## Operation
- Mode 0: `mosi` is sampled on `scl` rising edges. `miso` changes on `scl` falling edges. The first bit is driven from `cs` falling.
- States:
  - RESYNC: entered from reset. Exits to IDLE when synchronised `cs` = 1, so the block never joins a frame mid-way.
  - IDLE: on `cs` fall, load `tx_byte` into the tx shifter, pulse `tx_ready`, clear `bit_cnt`, drive the first bit, go to ACTIVE.
  - ACTIVE: runs the byte loop below.
- ACTIVE, on `scl` rise:
  - Shift `mosi` into the rx shifter at the end selected by `msb_lsb`.
  - `bit_cnt` increments (3-bit, wraps 7→0).
  - On the 8th rise (`bit_cnt` 7→0): `rx_byte` ← shifter, pulse `rx_valid`, set internal flag `reload`.
- ACTIVE, on `scl` fall:
  - If `reload` is set: latch `tx_byte`, pulse `tx_ready`, drive its first bit, clear `reload`.
  - Otherwise: advance `miso` to the next bit.
- ACTIVE, on `cs` rise (at any `bit_cnt`): pulse `frame_end`, go to IDLE, drive `miso` 0.
  - A partial byte is discarded: no `rx_valid`, `rx_byte` unchanged.
- Simultaneous `cs` rise and `scl` edge in the same synchronised cycle: `cs` wins and the `scl` edge is ignored.
- `scl` edges in IDLE or RESYNC are ignored.
- `tx_byte` is not double-buffered. The user updates it after the `tx_ready` pulse and before the next byte boundary.
  - If the user does not update it, the same byte is resent.
- `msb_lsb` is latched with each `tx_byte` load and applies to both rx and tx for that byte.

## Timing
- Reset values: `miso`=0, `rx_byte`=0, `rx_valid`=0, `tx_ready`=0, `busy`=0, `frame_end`=0, state=RESYNC.
- Synchroniser reset values: `cs`=1, `scl`=0, `mosi`=0.
- Edge-detect latency: SYNC_STAGES+1 `clk` cycles from a pin edge to the internal edge strobe.
- `miso` is registered and valid 1 cycle after the strobe, i.e. SYNC_STAGES+2 cycles after the pin edge.
- `rx_valid` asserts in the cycle after the 8th rise strobe.
- Half SCL period must be ≥ SYNC_STAGES+3 `clk` cycles. This is met at 10 MHz / 1 MHz.
- All pulse outputs are exactly 1 cycle wide.
- `arstn` asserted mid-frame: the block resets immediately, then sits in RESYNC until `cs` goes high.

## Structure
- Package `spi_pkg`:
  - `spi_slave_state_t` enum {RESYNC, IDLE, ACTIVE}.
  - `SPI_BYTE_W` = 8.
  - `SPI_BITCNT_W` = 3.
- Sub-module `spi_sync_edge`: SYNC_STAGES flop chain plus one delay flop, with outputs `level`, `rise`, `fall`. Instantiated for `scl` and `cs`. For `mosi` only `level` is used.

## Test plan
- Single byte, MSB first: master sends 0xA5 with `tx_byte`=0x3C.
  - `rx_valid` pulses once with `rx_byte`=0xA5.
  - Master receives 0x3C.
  - `frame_end` pulses once.
- Continuous transfer: 50 bytes 56..105 with `cs` held low, `tx_byte` stepped on each `tx_ready`.
  - 50 `rx_valid` pulses, in order.
  - Master reads back the stepped sequence.
- LSB first: `msb_lsb`=1, master sends 0x01.
  - `rx_byte`=0x01.
  - `miso` emits bit0 first for `tx_byte`=0x80; master sees 0x80.
- Abort: `cs` raised after 5 `scl` rises.
  - No `rx_valid`; `rx_byte` keeps its previous value.
  - `frame_end` pulses, `busy` falls.
  - The next full byte is received correctly.
- Reset mid-frame: `arstn` pulsed low after 3 bits while `cs` stays low.
  - Outputs go to reset values.
  - No `rx_valid` until `cs` has gone high and a new frame sends 0x7E, which is then received as 0x7E.
